// File: rtl/outport_uart_tx_pkg.sv
// Shared constants and FSM encoding for the out-port UART transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package outport_uart_tx_pkg;

    // Default serial bit period in core clock cycles.
    localparam int CLKS_PER_BIT_DEFAULT = 16;

    // 8N1 frame: start + 8 data + stop.
    localparam int FRAME_BITS = 10;

    // A 32-bit out-port word is sent as four bytes.
    localparam int WORD_BYTES = 4;

    // Serializer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/outport_fifo.sv
// Word FIFO between the datapath out-port and the UART serializer.
// Latency: a pushed word is visible on rd_data / empty=0 the cycle after the push.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module outport_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign rd_data = r_mem[r_rd_ptr];

    // Storage is deliberately not reset; stale words are never read before rewrite.
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/outport_uart_tx.sv
// Out-port UART: buffers 32-bit words and sends each as four 8N1 bytes, LSB byte first.
// Latency: first START bit on tx two cycles after a write into an empty idle block.
// Backpressure: none upstream; writes to a full FIFO are dropped and flagged in overflow.
module outport_uart_tx
    import outport_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DEPTH        = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic        empty,
    output logic        overflow
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [1:0]  LAST_BYTE = 2'(WORD_BYTES - 1);

    tx_state_t   r_state;
    tx_state_t   w_state_nxt;
    logic [15:0] r_baud;
    logic [2:0]  r_bit_idx;
    logic [1:0]  r_byte_idx;
    logic [31:0] r_shift;
    logic        r_overflow;
    logic        w_pop;
    logic        w_bit_end;
    logic        w_full;
    logic        w_empty;
    logic [31:0] w_fifo_dat;

    outport_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock   (clock),
        .clear   (clear),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (w_pop),
        .rd_data (w_fifo_dat),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign w_bit_end = (r_baud == BAUD_LAST);
    assign full      = w_full;
    assign empty     = w_empty;
    assign busy      = (r_state != IDLE);
    assign overflow  = r_overflow;

    // Serializer state register.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, pop request and line level.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        tx          = 1'b1;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                tx = r_shift[0];
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = (r_byte_idx == LAST_BYTE) ? IDLE : START;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Baud counter, bit/byte indices and shift register; shifting right walks bytes LSB-first.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
        end else begin
            if ((r_state == IDLE) || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 16'd1;
            end
            if ((r_state == DATA) && w_bit_end) begin
                r_bit_idx <= r_bit_idx + 3'd1;
                r_shift   <= {1'b0, r_shift[31:1]};
            end
            if ((r_state == STOP) && w_bit_end) begin
                r_byte_idx <= r_byte_idx + 2'd1;
            end
            if (w_pop) begin
                r_shift    <= w_fifo_dat;
                r_bit_idx  <= '0;
                r_byte_idx <= '0;
            end
        end
    end

    // Sticky drop flag: a write hit a full FIFO with no pop to make room.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_outport_uart_tx.sv
// Directed bench for outport_uart_tx with CLKS_PER_BIT=4, DEPTH=4.
// Latency: tx/busy logged every falling edge and decoded after each scenario.
// Backpressure: exercises FIFO full, dropped writes and write-on-pop.
module tb_outport_uart_tx;
    import outport_uart_tx_pkg::*;

    localparam int CPB      = 4;
    localparam int DEP      = 4;
    localparam int WORD_CYC = WORD_BYTES * FRAME_BITS * CPB;   // 160
    localparam int LOG_N    = 8192;

    logic        clock;
    logic        clear;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        tx;
    logic        busy;
    logic        full;
    logic        empty;
    logic        overflow;

    int   compared = 0;
    int   mism     = 0;
    int   cyc      = 0;
    logic log_tx   [LOG_N];
    logic log_busy [LOG_N];

    outport_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEP)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Line recorder: one sample per falling edge.
    always @(negedge clock) begin
        if (cyc < LOG_N) begin
            log_tx[cyc]   = tx;
            log_busy[cyc] = busy;
        end
        cyc = cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx_at(input int c);
        if (c >= 0 && c < LOG_N && c < cyc) return log_tx[c];
        return 1'bx;
    endfunction

    function automatic int find_fall(input int from);
        for (int i = (from < 0 ? 0 : from); i < cyc && i < LOG_N; i++) begin
            if (log_tx[i] === 1'b0) return i;
        end
        return -1;
    endfunction

    function automatic int count_tx(input int lo, input int hi, input logic v);
        int n = 0;
        for (int i = lo; i < hi; i++) begin
            if (i >= 0 && i < LOG_N && log_tx[i] === v) n++;
        end
        return n;
    endfunction

    function automatic int count_busy(input int lo, input int hi, input logic v);
        int n = 0;
        for (int i = lo; i < hi; i++) begin
            if (i >= 0 && i < LOG_N && log_busy[i] === v) n++;
        end
        return n;
    endfunction

    // Each byte frame sampled at the first and last cycle of every bit period.
    task automatic check_word(input int base, input logic [31:0] w, input string tag);
        for (int b = 0; b < 4; b++) begin
            logic [9:0] f0;
            logic [9:0] f3;
            logic [9:0] ex;
            ex = {1'b1, w[8*b +: 8], 1'b0};
            for (int j = 0; j < 10; j++) begin
                f0[j] = tx_at(base + (10*b + j)*CPB);
                f3[j] = tx_at(base + (10*b + j)*CPB + CPB - 1);
            end
            check($sformatf("%s_byte%0d_first", tag, b), 64'(f0), 64'(ex));
            check($sformatf("%s_byte%0d_last", tag, b), 64'(f3), 64'(ex));
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(busy === 1'b0 && empty === 1'b1) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_idle_timeout"}, 64'(n < 3000), 64'(1));
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        clear = 1'b0;
        repeat (2) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
    endtask

    logic [31:0] w2 [6];
    logic [31:0] w3 [6];
    int s;
    int from;
    int n;

    initial begin
        w2 = '{32'h11111111, 32'h22223333, 32'h4455AA66, 32'h0F0F0F0F, 32'hDEADBEEF, 32'hCAFEF00D};
        w3 = '{32'h01234567, 32'h89ABCDEF, 32'h80000001, 32'h7FFFFFFE, 32'h13579BDF, 32'h2468ACE0};
        clear   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 32'h0;
        repeat (3) @(negedge clock);

        // Reset state.
        check("rst_tx", 64'(tx), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_full", 64'(full), 64'(0));
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_overflow", 64'(overflow), 64'(0));
        clear = 1'b1;
        @(negedge clock);

        // Single word 0xA5C30F81.
        from    = cyc;
        wr_data = 32'hA5C30F81;
        wr_en   = 1'b1;
        @(negedge clock);
        wr_en = 1'b0;
        check("t1_busy_after_write", 64'(busy), 64'(0));
        check("t1_empty_after_write", 64'(empty), 64'(0));
        @(negedge clock);
        check("t1_busy_after_pop", 64'(busy), 64'(1));
        check("t1_tx_start", 64'(tx), 64'(0));
        repeat (WORD_CYC + 20) @(negedge clock);
        s = find_fall(from);
        check("t1_start_found", 64'(s >= 0), 64'(1));
        if (s < 0) s = 0;
        check_word(s, 32'hA5C30F81, "t1");
        check("t1_busy_cycles", 64'(count_busy(s, s + WORD_CYC + 15, 1'b1)), 64'(160));
        check("t1_idle_tx_low", 64'(count_tx(s + WORD_CYC, s + WORD_CYC + 15, 1'b0)), 64'(0));
        check("t1_tx_idle", 64'(tx), 64'(1));
        check("t1_busy_idle", 64'(busy), 64'(0));

        // Six back-to-back writes: one popped, four buffered, sixth dropped.
        from = cyc;
        for (int k = 0; k < 6; k++) begin
            wr_data = w2[k];
            wr_en   = 1'b1;
            @(negedge clock);
            if (k == 4) begin
                check("t2_full_after5", 64'(full), 64'(1));
                check("t2_ovf_after5", 64'(overflow), 64'(0));
            end
        end
        wr_en = 1'b0;
        check("t2_full_after6", 64'(full), 64'(1));
        check("t2_ovf_after6", 64'(overflow), 64'(1));
        wait_idle("t2");
        repeat (30) @(negedge clock);
        s = find_fall(from);
        check("t2_start_found", 64'(s >= 0), 64'(1));
        if (s < 0) s = 0;
        for (int k = 0; k < 5; k++) begin
            check_word(s + k*(WORD_CYC + 1), w2[k], $sformatf("t2_w%0d", k));
        end
        check("t2_no_sixth_frame", 64'(count_tx(s + 5*(WORD_CYC + 1) - 1, cyc, 1'b0)), 64'(0));
        check("t2_ovf_sticky", 64'(overflow), 64'(1));

        // Write on the exact cycle a full FIFO pops.
        pulse_reset();
        check("t3_ovf_cleared", 64'(overflow), 64'(0));
        from = cyc;
        for (int k = 0; k < 5; k++) begin
            wr_data = w3[k];
            wr_en   = 1'b1;
            @(negedge clock);
        end
        wr_en = 1'b0;
        check("t3_full_before", 64'(full), 64'(1));
        check("t3_ovf_before", 64'(overflow), 64'(0));
        n = 0;
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("t3_gap_timeout", 64'(n < 400), 64'(1));
        wr_data = w3[5];
        wr_en   = 1'b1;
        @(negedge clock);
        wr_en = 1'b0;
        check("t3_full_after_pushpop", 64'(full), 64'(1));
        check("t3_ovf_after_pushpop", 64'(overflow), 64'(0));
        check("t3_busy_after_pop", 64'(busy), 64'(1));
        wait_idle("t3");
        repeat (5) @(negedge clock);
        s = find_fall(from);
        check("t3_start_found", 64'(s >= 0), 64'(1));
        if (s < 0) s = 0;
        for (int k = 0; k < 6; k++) begin
            check_word(s + k*(WORD_CYC + 1), w3[k], $sformatf("t3_w%0d", k));
        end
        check("t3_ovf_final", 64'(overflow), 64'(0));

        // Reset during DATA bit 3 of byte 1 (byte 0x56: bit2=1, bit3=0).
        wr_data = 32'h12345678;
        wr_en   = 1'b1;
        @(negedge clock);
        wr_en = 1'b0;
        @(negedge clock);
        check("t4_tx_start", 64'(tx), 64'(0));
        repeat (53) @(negedge clock);
        check("t4_b1_bit2", 64'(tx), 64'(1));
        repeat (4) @(negedge clock);
        check("t4_b1_bit3", 64'(tx), 64'(0));
        #2;
        clear = 1'b0;
        #1;
        check("t4_async_tx", 64'(tx), 64'(1));
        check("t4_async_busy", 64'(busy), 64'(0));
        check("t4_async_empty", 64'(empty), 64'(1));
        check("t4_async_full", 64'(full), 64'(0));
        @(negedge clock);
        clear = 1'b1;
        from  = cyc;
        repeat (200) @(negedge clock);
        check("t4_no_spurious_tx", 64'(count_tx(from, cyc, 1'b0)), 64'(0));
        check("t4_no_spurious_busy", 64'(count_busy(from, cyc, 1'b1)), 64'(0));

        // 0x00000000 then 0xFFFFFFFF: exactly one idle cycle between words.
        from    = cyc;
        wr_data = 32'h00000000;
        wr_en   = 1'b1;
        @(negedge clock);
        wr_data = 32'hFFFFFFFF;
        @(negedge clock);
        wr_en = 1'b0;
        wait_idle("t5");
        repeat (5) @(negedge clock);
        s = find_fall(from);
        check("t5_start_found", 64'(s >= 0), 64'(1));
        if (s < 0) s = 0;
        check_word(s, 32'h00000000, "t5_w0");
        check_word(s + WORD_CYC + 1, 32'hFFFFFFFF, "t5_w1");
        check("t5_last_stop", 64'(tx_at(s + WORD_CYC - 1)), 64'(1));
        check("t5_idle_tx", 64'(tx_at(s + WORD_CYC)), 64'(1));
        check("t5_idle_busy", 64'(log_busy[s + WORD_CYC]), 64'(0));
        check("t5_gap", 64'(find_fall(s + WORD_CYC) - s), 64'(161));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
